combat_resolver: RTL
====================

# combat_resolver

Frame-rate arbiter between the two per-player sprite FSMs. Each cycle (one video frame) it takes both players' 4-bit FSM states and updates their horizontal positions, including walk steps, arena clamping and body collision. It detects attacks that connect and returns single-cycle `got_hit` / `got_blocked` pulses to the defending FSM. It also keeps per-player hit scores and declares the round over.

## Interface
- `X_W`, 10: position width.
- `ARENA_MIN`, 32: leftmost legal x.
- `ARENA_MAX`, 607: rightmost legal x.
- `P1_START`, 160: P1 reset x.
- `P2_START`, 480: P2 reset x.
- `WALK_FWD`, 3: forward step per cycle.
- `WALK_BACK`, 2: backward step per cycle.
- `BODY_W`, 32: minimum `p2_x - p1_x`.
- `ATK_REACH`, 48: basic attack reach.
- `DIRATK_REACH`, 64: directional attack reach.
- `WIN_HITS`, 3: hits needed to win (≤3).

Ports:
- `clk` in 1: frame clock, rising edge.
- `reset_n` in 1: synchronous, active-low.
- `p1_state` in 4: P1 FSM state code.
- `p2_state` in 4: P2 FSM state code.
- `p1_x` out X_W: P1 position, registered.
- `p2_x` out X_W: P2 position, registered.
- `p1_got_hit` out 1: pulse to P1 FSM.
- `p1_got_blocked` out 1: pulse to P1 FSM.
- `p2_got_hit` out 1: pulse to P2 FSM.
- `p2_got_blocked` out 1: pulse to P2 FSM.
- `p1_score` out 2: hits landed by P1.
- `p2_score` out 2: hits landed by P2.
- `round_over` out 1: sticky end-of-round flag.

## Operation
- State codes:
  - 0 idle, 1 backward, 2 forward.
  - 3–5 attack start/active/recovery.
  - 6–8 directional attack start/active/recovery.
  - 9 hitstun, 10 blockstun.
  - Any other code is treated as idle.
- Facing: P1 faces +x, P2 faces −x. Forward for P1 is +x; forward for P2 is −x.
- Movement candidates:
  - Backward step applies first, clamped: P1 to ≥ `ARENA_MIN`, P2 to ≤ `ARENA_MAX`.
  - Forward step is then added.
  - If the candidate gap `p2 − p1` < `BODY_W`, both forward steps are cancelled and backward steps are kept. The invariant gap ≥ `BODY_W` therefore always holds.
  - All other states (attack, stun) leave the position unchanged.
- Hit detection uses the registered positions from the start of the cycle, with `d = p2_x − p1_x`.
  - Attacker is active with reach R when its state is 4 (R=`ATK_REACH`) or 7 (R=`DIRATK_REACH`).
  - A connect occurs when `d ≤ R` and the attacker's `used` latch is 0. The connect sets `used`.
  - `used` clears on any cycle the attacker's state is neither 4 nor 7, so an attack connects at most once per active window.
- Defender response to a connect:
  - Defender state is 1 or 10: `got_blocked`.
  - Any other defender state: `got_hit`.
  - `got_hit` and `got_blocked` are never asserted together for one player.
- Trades: both players may connect in the same cycle. Each then receives its own pulse.
- Score:
  - Each `got_hit` delivered to the opponent increments the attacker's score, saturating at `WIN_HITS`.
  - Blocks do not score.
- `round_over`:
  - Sets the cycle after either score reaches `WIN_HITS`.
  - Once set, positions freeze, all pulses are forced 0, and scores hold until reset.
  - A draw is both scores equal to `WIN_HITS`.
- Reset (`reset_n`=0 at an edge), including mid-round:
  - `p1_x`=`P1_START`, `p2_x`=`P2_START`.
  - All pulses 0, scores 0, `used` latches 0, `round_over`=0.

## Timing
- Registered outputs. States sampled at edge N give positions and pulses visible after edge N (cycle N+1).
- Pulses are exactly one cycle wide. The FSM samples them at edge N+1.
- Position and hit evaluation use the same pre-move positions, so a step taken in cycle N affects range checks from cycle N+1.
- Arithmetic:
  - Candidates are computed in X_W+1 bits signed, so underflow and overflow are clamped rather than wrapped.
  - The gap compare is signed.
- An attack held active across 2 cycles (basic) or 3 cycles (directional) in range produces one pulse, on the first active cycle + 1.

## Test plan
- Reset:
  - Drive `reset_n`=0 for 2 cycles.
  - Expect x = 160/480, scores 0, `round_over`=0, all pulses 0.
- Collision:
  - P1 state 2, P2 state 0, for 120 cycles.
  - Expect P1 at 448 after 96 cycles, then holding at 448 (gap 32).
- Arena clamp: P1 state 1 for 80 cycles → `p1_x` reaches 32 at cycle 64 and holds.
- Hit vs block, with gap 32:
  - P1 sequence 3,4,4,5 and P2 idle: `p2_got_hit` high exactly 1 cycle, `p1_score`=1.
  - Repeat with P2 in state 1: `p2_got_blocked` pulse only, score unchanged.
- Range:
  - Gap 56: basic attack gives no pulse; directional attack (state 7) hits.
  - Gap 65: directional attack gives no pulse.
- Trade and round end:
  - Both players in state 4 simultaneously at gap 32: both `got_hit` pulses in the same cycle.
  - Three such trades give scores 3/3 and `round_over`=1. Further attacks produce no pulses and positions stay frozen.
  - `reset_n` low then restores reset values.

Source files
------------

// File: rtl/combat_resolver_if.sv
`default_nettype none
// ============================================================================
//  Module      : combat_resolver_if
//  Description : Frame-rate link between the two player sprite FSMs and the
//                combat resolver. It carries the FSM state codes in one
//                direction and the positions, hit/block pulses, scores and
//                round status in the other.
//  Revision    : 1.0 - initial release
// ============================================================================
interface combat_resolver_if #(
  parameter int X_W = 10
);
  logic [3:0]     p1_state;
  logic [3:0]     p2_state;
  logic [X_W-1:0] p1_x;
  logic [X_W-1:0] p2_x;
  logic           p1_got_hit;
  logic           p1_got_blocked;
  logic           p2_got_hit;
  logic           p2_got_blocked;
  logic [1:0]     p1_score;
  logic [1:0]     p2_score;
  logic           round_over;

  // FSM side: drives the state codes and consumes everything else
  modport master (
    output p1_state, p2_state,
    input  p1_x, p2_x,
    input  p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
    input  p1_score, p2_score, round_over
  );

  // Resolver side
  modport slave (
    input  p1_state, p2_state,
    output p1_x, p2_x,
    output p1_got_hit, p1_got_blocked, p2_got_hit, p2_got_blocked,
    output p1_score, p2_score, round_over
  );
endinterface
`default_nettype wire

// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : combat_resolver
//  Description : Per-frame arbiter for two fighters. Moves both players with
//                arena clamping and body collision, detects attacks that
//                connect, returns one-cycle hit/block pulses to the defender,
//                keeps saturating hit scores and flags the end of the round.
//  Revision    : 1.0 - initial release
// ============================================================================
module combat_resolver #(
  parameter int X_W          = 10,
  parameter int ARENA_MIN    = 32,
  parameter int ARENA_MAX    = 607,
  parameter int P1_START     = 160,
  parameter int P2_START     = 480,
  parameter int WALK_FWD     = 3,
  parameter int WALK_BACK    = 2,
  parameter int BODY_W       = 32,
  parameter int ATK_REACH    = 48,
  parameter int DIRATK_REACH = 64,
  parameter int WIN_HITS     = 3
) (
  input  wire               clk,
  input  wire               reset_n,
  combat_resolver_if.slave  bus
);

  // State codes seen from the sprite FSMs
  localparam logic [3:0] c_st_back      = 4'd1;
  localparam logic [3:0] c_st_fwd       = 4'd2;
  localparam logic [3:0] c_st_atk_act   = 4'd4;
  localparam logic [3:0] c_st_dir_act   = 4'd7;
  localparam logic [3:0] c_st_blockstun = 4'd10;

  // Signed arithmetic is one bit wider than a position so clamps never wrap
  localparam logic signed [X_W:0] c_arena_min = (X_W+1)'(ARENA_MIN);
  localparam logic signed [X_W:0] c_arena_max = (X_W+1)'(ARENA_MAX);
  localparam logic signed [X_W:0] c_walk_fwd  = (X_W+1)'(WALK_FWD);
  localparam logic signed [X_W:0] c_walk_back = (X_W+1)'(WALK_BACK);
  localparam logic signed [X_W:0] c_body_w    = (X_W+1)'(BODY_W);
  localparam logic signed [X_W:0] c_atk_reach = (X_W+1)'(ATK_REACH);
  localparam logic signed [X_W:0] c_dir_reach = (X_W+1)'(DIRATK_REACH);
  localparam logic [X_W-1:0]      c_p1_start  = X_W'(P1_START);
  localparam logic [X_W-1:0]      c_p2_start  = X_W'(P2_START);
  localparam logic [1:0]          c_win_hits  = 2'(WIN_HITS);

  logic [X_W-1:0] p1_x_q, p1_x_d;
  logic [X_W-1:0] p2_x_q, p2_x_d;
  logic           p1_got_hit_q, p1_got_hit_d;
  logic           p1_got_blocked_q, p1_got_blocked_d;
  logic           p2_got_hit_q, p2_got_hit_d;
  logic           p2_got_blocked_q, p2_got_blocked_d;
  logic [1:0]     p1_score_q, p1_score_d;
  logic [1:0]     p2_score_q, p2_score_d;
  logic           p1_used_q, p1_used_d;
  logic           p2_used_q, p2_used_d;
  logic           round_over_q, round_over_d;

  logic [3:0]            w_p1_st, w_p2_st;
  logic signed [X_W:0]   w_p1_back, w_p2_back;
  logic signed [X_W:0]   w_p1_fwd, w_p2_fwd;
  logic signed [X_W:0]   w_gap_now;
  logic                  w_p1_active, w_p2_active;
  logic signed [X_W:0]   w_p1_reach, w_p2_reach;
  logic                  w_p1_connect, w_p2_connect;
  logic                  w_p1_guard, w_p2_guard;

  // Undefined codes behave as idle
  function automatic logic [3:0] norm_state(input logic [3:0] s);
    return (s > 4'd10) ? 4'd0 : s;
  endfunction

  // Next-frame positions, hit detection, scoring and round status
  always_comb begin
    w_p1_st = norm_state(bus.p1_state);
    w_p2_st = norm_state(bus.p2_state);

    // Backward step first (clamped to the arena), then forward step
    w_p1_back = $signed({1'b0, p1_x_q}) - ((w_p1_st == c_st_back) ? c_walk_back : '0);
    if (w_p1_back < c_arena_min) w_p1_back = c_arena_min;
    w_p2_back = $signed({1'b0, p2_x_q}) + ((w_p2_st == c_st_back) ? c_walk_back : '0);
    if (w_p2_back > c_arena_max) w_p2_back = c_arena_max;
    w_p1_fwd = w_p1_back + ((w_p1_st == c_st_fwd) ? c_walk_fwd : '0);
    w_p2_fwd = w_p2_back - ((w_p2_st == c_st_fwd) ? c_walk_fwd : '0);

    // Bodies may not overlap: drop both forward steps, keep the retreats
    if ((w_p2_fwd - w_p1_fwd) < c_body_w) begin
      p1_x_d = w_p1_back[X_W-1:0];
      p2_x_d = w_p2_back[X_W-1:0];
    end else begin
      p1_x_d = w_p1_fwd[X_W-1:0];
      p2_x_d = w_p2_fwd[X_W-1:0];
    end

    // Range checks use the pre-move positions
    w_gap_now   = $signed({1'b0, p2_x_q}) - $signed({1'b0, p1_x_q});
    w_p1_active = (w_p1_st == c_st_atk_act) || (w_p1_st == c_st_dir_act);
    w_p2_active = (w_p2_st == c_st_atk_act) || (w_p2_st == c_st_dir_act);
    w_p1_reach  = (w_p1_st == c_st_dir_act) ? c_dir_reach : c_atk_reach;
    w_p2_reach  = (w_p2_st == c_st_dir_act) ? c_dir_reach : c_atk_reach;
    w_p1_connect = w_p1_active && (w_gap_now <= w_p1_reach) && !p1_used_q && !round_over_q;
    w_p2_connect = w_p2_active && (w_gap_now <= w_p2_reach) && !p2_used_q && !round_over_q;

    // A connect latches until the attacker leaves its active states
    p1_used_d = w_p1_active && (p1_used_q || w_p1_connect);
    p2_used_d = w_p2_active && (p2_used_q || w_p2_connect);

    w_p1_guard = (w_p1_st == c_st_back) || (w_p1_st == c_st_blockstun);
    w_p2_guard = (w_p2_st == c_st_back) || (w_p2_st == c_st_blockstun);

    p2_got_hit_d     = w_p1_connect && !w_p2_guard;
    p2_got_blocked_d = w_p1_connect &&  w_p2_guard;
    p1_got_hit_d     = w_p2_connect && !w_p1_guard;
    p1_got_blocked_d = w_p2_connect &&  w_p1_guard;

    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    if (p2_got_hit_d && (p1_score_q < c_win_hits)) p1_score_d = p1_score_q + 2'd1;
    if (p1_got_hit_d && (p2_score_q < c_win_hits)) p2_score_d = p2_score_q + 2'd1;

    round_over_d = round_over_q || (p1_score_q == c_win_hits) || (p2_score_q == c_win_hits);

    // A finished round freezes the arena until reset
    if (round_over_q) begin
      p1_x_d = p1_x_q;
      p2_x_d = p2_x_q;
    end
  end

  // Frame registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p1_x_q           <= c_p1_start;
      p2_x_q           <= c_p2_start;
      p1_got_hit_q     <= 1'b0;
      p1_got_blocked_q <= 1'b0;
      p2_got_hit_q     <= 1'b0;
      p2_got_blocked_q <= 1'b0;
      p1_score_q       <= 2'd0;
      p2_score_q       <= 2'd0;
      p1_used_q        <= 1'b0;
      p2_used_q        <= 1'b0;
      round_over_q     <= 1'b0;
    end else begin
      p1_x_q           <= p1_x_d;
      p2_x_q           <= p2_x_d;
      p1_got_hit_q     <= p1_got_hit_d;
      p1_got_blocked_q <= p1_got_blocked_d;
      p2_got_hit_q     <= p2_got_hit_d;
      p2_got_blocked_q <= p2_got_blocked_d;
      p1_score_q       <= p1_score_d;
      p2_score_q       <= p2_score_d;
      p1_used_q        <= p1_used_d;
      p2_used_q        <= p2_used_d;
      round_over_q     <= round_over_d;
    end
  end

  assign bus.p1_x           = p1_x_q;
  assign bus.p2_x           = p2_x_q;
  assign bus.p1_got_hit     = p1_got_hit_q;
  assign bus.p1_got_blocked = p1_got_blocked_q;
  assign bus.p2_got_hit     = p2_got_hit_q;
  assign bus.p2_got_blocked = p2_got_blocked_q;
  assign bus.p1_score       = p1_score_q;
  assign bus.p2_score       = p2_score_q;
  assign bus.round_over     = round_over_q;

endmodule
`default_nettype wire
